// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the five-stage core.
// Merges per-stage stall requests into the 6-bit stall vector, converts MEM-stage
// exceptions into a single-cycle flush with a redirect PC, and enforces one
// recovery cycle after every flush. A watchdog flags runaway stalls.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the stall-cycle and flush
// performance counters. When it is undefined, both ports read as zero.
module pipe_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
);

    localparam int unsigned    CW      = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN,
        STALLED,
        RECOVER
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] run_cnt;
    logic          timeout_q;

    logic [5:0]    stall_c;
    logic          flush_c;
    logic [31:0]   new_pc_c;

    // Same-cycle stall/flush/redirect decode and next-state selection
    always_comb begin
        stall_c   = '0;
        flush_c   = 1'b0;
        new_pc_c  = '0;
        state_nxt = RUN;
        if (state == RECOVER) begin
            // MEM holds a bubble and ID/EX/MEM requests are stale here
            if (stallreq_from_if) begin
                stall_c = 6'b000011;
            end
        end else if (excepttype_i != '0) begin
            flush_c   = 1'b1;
            state_nxt = RECOVER;
            case (excepttype_i)
                32'h0000_0001: new_pc_c = INT_VECTOR;
                32'h0000_000e: new_pc_c = cp0_epc_i;
                default:       new_pc_c = EXC_VECTOR;
            endcase
        end else if (stallreq_from_mem) begin
            stall_c = 6'b011111;
        end else if (stallreq_from_ex) begin
            stall_c = 6'b001111;
        end else if (stallreq_from_id) begin
            stall_c = 6'b000111;
        end else if (stallreq_from_if) begin
            stall_c = 6'b000011;
        end
        if (stall_c != '0) begin
            state_nxt = STALLED;
        end
    end

    assign stall         = rst ? '0   : stall_c;
    assign flush         = rst ? 1'b0 : flush_c;
    assign new_pc        = rst ? '0   : new_pc_c;
    assign stall_timeout = rst ? 1'b0 : timeout_q;

    // State register plus saturating consecutive-stall watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            run_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (stall_c != '0 && !flush_c) begin
                if (run_cnt == CNT_MAX) begin
                    timeout_q <= 1'b1;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Free-running performance counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_c != '0) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_c) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = rst ? '0 : perf_stall_q;
    assign perf_flush_count  = rst ? '0 : perf_flush_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random traffic,
// checked through an expectation queue against a behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned TO      = 4;
    localparam logic [31:0] INT_VEC = 32'h0000_0020;
    localparam logic [31:0] EXC_VEC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sif = 1'b0, sid = 1'b0, sex = 1'b0, smem = 1'b0;
    logic [31:0] exc = '0, epc = '0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] perf_stall_cycles, perf_flush_count;

    pipe_ctrl #(
        .STALL_TIMEOUT (TO),
        .INT_VECTOR    (INT_VEC),
        .EXC_VECTOR    (EXC_VEC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (sif),
        .stallreq_from_id  (sid),
        .stallreq_from_ex  (sex),
        .stallreq_from_mem (smem),
        .excepttype_i      (exc),
        .cp0_epc_i         (epc),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_timeout     (stall_timeout),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        to;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    // Reference model state: abstract counters, not the DUT's encoding
    bit          m_rec  = 1'b0;
    int unsigned m_run  = 0;
    bit          m_flag = 1'b0;
    logic [31:0] m_ps   = '0;
    logic [31:0] m_pf   = '0;

    task automatic drive(input bit r, input bit i_if, input bit i_id, input bit i_ex,
                         input bit i_mem, input logic [31:0] i_exc, input logic [31:0] i_epc);
        exp_t e;
        @(negedge clk);
        rst = r; sif = i_if; sid = i_id; sex = i_ex; smem = i_mem; exc = i_exc; epc = i_epc;
        e.stall = '0; e.flush = 1'b0; e.pc = '0; e.to = 1'b0; e.ps = '0; e.pf = '0;
        if (!r) begin
            if (m_rec) begin
                e.stall = i_if ? 6'd3 : 6'd0;
            end else if (i_exc != 0) begin
                e.flush = 1'b1;
                if (i_exc == 32'd1)       e.pc = INT_VEC;
                else if (i_exc == 32'd14) e.pc = i_epc;
                else                      e.pc = EXC_VEC;
            end else begin
                e.stall = i_mem ? 6'd31 : i_ex ? 6'd15 : i_id ? 6'd7 : i_if ? 6'd3 : 6'd0;
            end
            e.to = m_flag;
`ifdef PIPE_CTRL_PERF_EN
            e.ps = m_ps;
            e.pf = m_pf;
`endif
        end
        q.push_back(e);
        // advance the model to what the coming clock edge produces
        if (r) begin
            m_rec = 1'b0; m_run = 0; m_flag = 1'b0; m_ps = '0; m_pf = '0;
        end else begin
            m_rec = e.flush;
            if (e.stall != 0) begin
                if (m_run < TO) m_run++;
                if (m_run >= TO) m_flag = 1'b1;
                m_ps = m_ps + 32'd1;
            end else begin
                m_run = 0;
            end
            if (e.flush) m_pf = m_pf + 32'd1;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp("stall",         {26'd0, stall}, {26'd0, e.stall});
                cmp("flush",         {31'd0, flush}, {31'd0, e.flush});
                cmp("new_pc",        new_pc, e.pc);
                cmp("stall_timeout", {31'd0, stall_timeout}, {31'd0, e.to});
                cmp("perf_stall",    perf_stall_cycles, e.ps);
                cmp("perf_flush",    perf_flush_count, e.pf);
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] codes [8];
        codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'ha; codes[3] = 32'hc;
        codes[4] = 32'hd; codes[5] = 32'he; codes[6] = 32'h5; codes[7] = 32'h8000_0003;

        // reset
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        // ex stall for 3 cycles then idle
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        // mem + id, then drop mem
        drive(0, 0, 1, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        // eret with ex stall, then recover cycle with same inputs
        drive(0, 0, 0, 1, 0, 32'he, 32'h0000_1234);
        drive(0, 0, 0, 1, 0, 32'he, 32'h0000_1234);
        drive(0, 0, 0, 0, 0, 0, 0);
        // vector selection
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, codes[i], 32'hdead_beef);
            drive(0, 0, 0, 0, 0, 0, 0);
        end
        // watchdog: IF held past the timeout, then dropped, then reset
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        // reset during RECOVER with IF request, request persists after reset
        drive(0, 1, 0, 0, 0, 32'h8, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ex_r;
            ex_r = 0;
            if ($urandom_range(0, 99) < 15) begin
                ex_r = ($urandom_range(0, 3) == 0) ? $urandom() : codes[$urandom_range(0, 7)];
            end
            drive(($urandom_range(0, 99) < 3), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) == 0), ex_r, $urandom());
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        done = 1'b1;
    end

    // End of test: drain the queue within a bounded number of cycles
    initial begin
        wait (done);
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #3;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL time_limit: simulation still running at %0t, expected completion", $time);
        $fatal(1, "time limit");
    end

endmodule
